div_seq: RTL and testbench

- Sequential restoring divider; the inverse companion to the team's combinational add/sub slice.
- Turns repeated trial subtraction into division: one quotient bit per clock.
- Sits beside the ALU in the WISC datapath as a multi-cycle functional unit.
- Start/ready/done handshake lets the pipeline stall on it.

---
 rtl/div_seq_pkg.sv | 18 +
 rtl/div_sub_step.sv | 18 +
 rtl/div_seq.sv | 147 ++++++++++++++
 tb/tb_div_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default width and the iteration counter width.
package div_seq_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_FIX  = 2'b11
  } state_t;

  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// WIDTH+1-bit trial subtract built as a + ~b + 1 on the carry chain;
// borrow is the inverted carry-out.
module div_sub_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  logic [WIDTH+1:0] sum;

  assign sum    = {1'b0, a} + {1'b0, ~b} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign diff   = sum[WIDTH:0];
  assign borrow = ~sum[WIDTH+1];

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (adds a FIX state).
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output state_t           dbg_state
);

  // Handshake: start is accepted only on a rising edge where ready=1; done is
  // a one-cycle pulse, and quotient/remainder/div_by_zero are valid from it
  // until the next accepted start.

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] rem_reg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             unused_diff_msb;

  assign dbg_state = state;

  // rem is always below d_reg, so the full rem plus the next dividend bit fits
  // in WIDTH+1 bits even for divisors at or above 2^(WIDTH-1).
  assign shifted = {rem_reg, q_reg[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .a      (shifted),
    .b      ({1'b0, d_reg}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign rem_next        = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_next          = {q_reg[WIDTH-2:0], ~borrow};
  assign unused_diff_msb = diff[WIDTH];

`ifdef DIV_SIGNED_EN
  logic q_neg;
  logic r_neg;

  assign a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign b_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      rem_reg     <= '0;
`ifdef DIV_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            q_reg       <= a_mag;
            d_reg       <= b_mag;
            rem_reg     <= '0;
            div_by_zero <= 1'b0;
            ready       <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg       <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= S_DONE;
            end else begin
              count <= CW'(WIDTH - 1);
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          q_reg   <= q_next;
          rem_reg <= rem_next;
          count   <= count - 1'b1;
          if (count == '0) begin
`ifdef DIV_SIGNED_EN
            state <= S_FIX;
`else
            quotient  <= q_next;
            remainder <= rem_next;
            done      <= 1'b1;
            state     <= S_DONE;
`endif
          end
        end
`ifdef DIV_SIGNED_EN
        S_FIX: begin
          quotient  <= q_neg ? (~q_reg + 1'b1) : q_reg;
          remainder <= r_neg ? (~rem_reg + 1'b1) : rem_reg;
          done      <= 1'b1;
          state     <= S_DONE;
        end
`endif
        S_DONE: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, results, divide-by-zero,
// busy-window start rejection and mid-operation reset.
module tb_div_seq;
  import div_seq_pkg::*;

  localparam int W = 16;
`ifdef DIV_SIGNED_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  state_t       dbg_state;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] exp_q[$];

  div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick; tick;
    rst = 1'b0;
    checks++;
    if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); end
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL reset_handshake: got ready=%b done=%b expected 1/0", ready, done); end
    checks++;
    if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got q=%h r=%h dbz=%b expected 0/0/0", quotient, remainder, div_by_zero);
    end
  endtask

  // Cycle n is the period after the n-th edge counting the accept edge as 1.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input int p0, input int p1);
    int done_at;
    int done_cnt;
    logic [W-1:0] got_q, got_r;
    logic got_dz;
    logic [2*W-1:0] exp;
    done_at = -1; done_cnt = 0; got_q = '0; got_r = '0; got_dz = 1'b0;
    exp_q.push_back({eq, er});
    dividend = a; divisor = b; start = 1'b1;
    tick;
    for (int c = 1; c <= lat + 2; c++) begin
      if (c == 1) begin
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL %s_busy: got ready=%b expected 0", name, ready); end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c; got_q = quotient; got_r = remainder; got_dz = div_by_zero;
        end
      end
      if (c == lat + 1) begin
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL %s_return: got ready=%b done=%b expected 1/0", name, ready, done); end
      end
      if (c == lat + 2) begin
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL %s_idle: got ready=%b expected 1", name, ready); end
        checks++;
        if (quotient !== eq || remainder !== er) begin
          errors++; $display("FAIL %s_hold: got q=%h r=%h expected q=%h r=%h", name, quotient, remainder, eq, er);
        end
        start = 1'b0;
      end else begin
        start    = (c == p0 || c == p1);
        dividend = W'($urandom_range(0, 65535));
        divisor  = W'($urandom_range(0, 65535));
        tick;
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if (done_at != lat || done_cnt != 1) begin
      errors++; $display("FAIL %s_latency: got done at cycle %0d (%0d pulses) expected cycle %0d (1 pulse)", name, done_at, done_cnt, lat);
    end
    checks++;
    if ({got_q, got_r} !== exp) begin
      errors++; $display("FAIL %s_result: got q=%h r=%h expected q=%h r=%h", name, got_q, got_r, exp[2*W-1:W], exp[W-1:0]);
    end
    checks++;
    if (got_dz !== edz) begin errors++; $display("FAIL %s_dbz: got %b expected %b", name, got_dz, edz); end
  endtask

  task automatic test_basic;
    run_op("div_100_7", 16'd100, 16'd7, LAT, 16'd14, 16'd2, 1'b0, -1, -1);
`ifdef DIV_SIGNED_EN
    run_op("div_ffff_1", 16'hFFFF, 16'h0001, LAT, 16'hFFFF, 16'h0000, 1'b0, -1, -1);
    run_op("div_ffff_8001", 16'hFFFF, 16'h8001, LAT, 16'h0000, 16'hFFFF, 1'b0, -1, -1);
`else
    run_op("div_ffff_1", 16'hFFFF, 16'h0001, LAT, 16'hFFFF, 16'h0000, 1'b0, -1, -1);
    run_op("div_ffff_8001", 16'hFFFF, 16'h8001, LAT, 16'h0001, 16'h7FFE, 1'b0, -1, -1);
`endif
  endtask

  task automatic test_div_by_zero;
    run_op("div_5_0", 16'd5, 16'd0, 1, 16'hFFFF, 16'd5, 1'b1, -1, -1);
    run_op("div_9_3", 16'd9, 16'd3, LAT, 16'd3, 16'd0, 1'b0, -1, -1);
  endtask

  task automatic test_busy_start;
    run_op("div_3_10", 16'd3, 16'd10, LAT, 16'd0, 16'd3, 1'b0, 4, LAT);
  endtask

  task automatic test_mid_reset;
    int done_seen;
    done_seen = 0;
    dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (done === 1'b1) done_seen++;
      rst = (c == 8);
      tick;
    end
    rst = 1'b0;
    checks++;
    if (dbg_state !== S_IDLE || ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset_state: got state=%0d ready=%b expected %0d/1", dbg_state, ready, S_IDLE);
    end
    checks++;
    if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got q=%h r=%h dbz=%b expected 0/0/0", quotient, remainder, div_by_zero);
    end
    for (int c = 9; c <= 25; c++) begin
      if (done === 1'b1) done_seen++;
      tick;
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d pulses expected 0", done_seen); end
    run_op("div_1000_3", 16'd1000, 16'd3, LAT, 16'd333, 16'd1, 1'b0, -1, -1);
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed;
    run_op("div_m7_2", 16'hFFF9, 16'h0002, LAT, 16'hFFFD, 16'hFFFF, 1'b0, -1, -1);
    run_op("div_min_m1", 16'h8000, 16'hFFFF, LAT, 16'h8000, 16'h0000, 1'b0, -1, -1);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_div_by_zero;
    test_busy_start;
    test_mid_reset;
`ifdef DIV_SIGNED_EN
    test_signed;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
